// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Forwarding is enabled by defining WB_FORWARD_EN (see regfile_wb_arbiter.sv).
package regfile_wb_arbiter_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int NUM_REGS   = 1 << DEF_ADDR_W;

  // Requester indices into the grant vector
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  // Round-robin priority state: which requester wins the next tie
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LD  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: ALU and load requesters plus the registered
// register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  reg_write, wr_addr, wr_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output reg_write, wr_addr, wr_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode, cleared by
// writeback (set wins on collision), popcount and RAW-hazard lookup.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              q_valid,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  input  logic              rs_bypass,
  input  logic              rt_bypass,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int N_REGS = 1 << ADDR_W;

  logic [N_REGS-1:0] pend_reg;
  logic [N_REGS-1:0] pend_next;
  logic [N_REGS-1:0] set_mask;
  logic [N_REGS-1:0] clr_mask;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;

  // A newer producer reserving the same index outranks the retiring write
  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_bit
    assign set_mask[gi]  = set_en & (set_addr == ADDR_W'(gi));
    assign clr_mask[gi]  = clr_en & (clr_addr == ADDR_W'(gi));
    assign pend_next[gi] = set_mask[gi] | (pend_reg[gi] & ~clr_mask[gi]);
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N_REGS; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign stall = q_valid & ((pend_reg[q_rs] & ~rs_bypass) |
                            (pend_reg[q_rt] & ~rt_bypass));
  assign pending_cnt = cnt_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with pending-write scoreboard. Define WB_FORWARD_EN to forward wr_data.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  input  logic [ADDR_W-1:0]   q_rs,
  input  logic [ADDR_W-1:0]   q_rt,
  input  logic                q_valid,
  output logic                stall,
  output logic [ADDR_W:0]     pending_cnt,
  output logic                rs_fwd,
  output logic                rt_fwd,
  output logic [DATA_W-1:0]   rs_fwd_data,
  output logic [DATA_W-1:0]   rt_fwd_data
);

  arb_state_e        state_reg;
  arb_state_e        state_next;
  logic [1:0]        grant;
  logic              both_valid;
  logic              reg_write_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              rs_hit;
  logic              rt_hit;

  assign both_valid = bus.alu_valid & bus.ld_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= PRI_ALU;
    else        state_reg <= state_next;
  end

  // Priority only moves after a real contention; a lone request keeps it
  always_comb begin
    state_next = state_reg;
    if (both_valid) begin
      state_next = (state_reg == PRI_ALU) ? PRI_LD : PRI_ALU;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      case (state_reg)
        PRI_ALU: begin
          grant[REQ_ALU] = bus.alu_valid;
          grant[REQ_LD]  = bus.ld_valid & ~bus.alu_valid;
        end
        PRI_LD: begin
          grant[REQ_LD]  = bus.ld_valid;
          grant[REQ_ALU] = bus.alu_valid & ~bus.ld_valid;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.alu_ready = grant[REQ_ALU];
  assign bus.ld_ready  = grant[REQ_LD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      reg_write_reg <= |grant;
      if (grant[REQ_ALU]) begin
        wr_addr_reg <= bus.alu_addr;
        wr_data_reg <= bus.alu_data;
      end else if (grant[REQ_LD]) begin
        wr_addr_reg <= bus.ld_addr;
        wr_data_reg <= bus.ld_data;
      end
    end
  end

  assign bus.reg_write = reg_write_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;

`ifdef WB_FORWARD_EN
  // The retiring write satisfies the operand, so its pending bit is ignored
  assign rs_hit      = reg_write_reg & (wr_addr_reg == q_rs);
  assign rt_hit      = reg_write_reg & (wr_addr_reg == q_rt);
  assign rs_fwd      = rs_hit;
  assign rt_fwd      = rt_hit;
  assign rs_fwd_data = rs_hit ? wr_data_reg : '0;
  assign rt_fwd_data = rt_hit ? wr_data_reg : '0;
`else
  assign rs_hit      = 1'b0;
  assign rt_hit      = 1'b0;
  assign rs_fwd      = 1'b0;
  assign rt_fwd      = 1'b0;
  assign rs_fwd_data = '0;
  assign rt_fwd_data = '0;
`endif

  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (sb_set),
    .set_addr    (sb_addr),
    .clr_en      (reg_write_reg),
    .clr_addr    (wr_addr_reg),
    .q_valid     (q_valid),
    .q_rs        (q_rs),
    .q_rt        (q_rt),
    .rs_bypass   (rs_hit),
    .rt_bypass   (rt_hit),
    .stall       (stall),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at grant
// time and popped when the registered write port should present them.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sb_set;
  logic [2:0] sb_addr;
  logic [2:0] q_rs;
  logic [2:0] q_rt;
  logic       q_valid;
  logic       stall;
  logic [3:0] pending_cnt;
  logic       rs_fwd;
  logic       rt_fwd;
  logic [7:0] rs_fwd_data;
  logic [7:0] rt_fwd_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic        rr_m;
  logic [7:0]  pend_m;
  logic        cur_v;
  logic [2:0]  cur_a;
  logic [7:0]  cur_d;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .q_rs        (q_rs),
    .q_rt        (q_rt),
    .q_valid     (q_valid),
    .stall       (stall),
    .pending_cnt (pending_cnt),
    .rs_fwd      (rs_fwd),
    .rt_fwd      (rt_fwd),
    .rs_fwd_data (rs_fwd_data),
    .rt_fwd_data (rt_fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rr_m   = 1'b0;
    pend_m = '0;
    cur_v  = 1'b0;
    cur_a  = '0;
    cur_d  = '0;
  endtask

  // One clock cycle: drive at edge+1, check combinational outputs mid-cycle,
  // then check the registered write port and scoreboard after the edge.
  task automatic step(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic lv, input logic [2:0] la, input logic [7:0] ld,
                      input logic ss, input logic [2:0] sa,
                      input logic qv, input logic [2:0] qr, input logic [2:0] qt);
    logic       g_alu, g_ld, rs_h, rt_h, e_stall;
    logic [10:0] e;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_addr  = la; bus.ld_data  = ld;
    sb_set = ss; sb_addr = sa; q_valid = qv; q_rs = qr; q_rt = qt;
    #4;
    g_alu = av & (~lv | ~rr_m);
    g_ld  = lv & (~av | rr_m);
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, g_alu});
    chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, g_ld});
`ifdef WB_FORWARD_EN
    rs_h = cur_v & (cur_a == qr);
    rt_h = cur_v & (cur_a == qt);
    chk("rs_fwd_data", {24'd0, rs_fwd_data}, rs_h ? {24'd0, cur_d} : 32'd0);
    chk("rt_fwd_data", {24'd0, rt_fwd_data}, rt_h ? {24'd0, cur_d} : 32'd0);
`else
    rs_h = 1'b0;
    rt_h = 1'b0;
    chk("rs_fwd_data", {24'd0, rs_fwd_data}, 32'd0);
    chk("rt_fwd_data", {24'd0, rt_fwd_data}, 32'd0);
`endif
    chk("rs_fwd", {31'd0, rs_fwd}, {31'd0, rs_h});
    chk("rt_fwd", {31'd0, rt_fwd}, {31'd0, rt_h});
    e_stall = qv & ((pend_m[qr] & ~rs_h) | (pend_m[qt] & ~rt_h));
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    if (g_alu)     exp_q.push_back({aa, ad});
    else if (g_ld) exp_q.push_back({la, ld});
    @(posedge clk);
    if (av && lv) rr_m = ~rr_m;
    if (cur_v) pend_m[cur_a] = 1'b0;
    if (ss)    pend_m[sa]    = 1'b1;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cur_v = 1'b1; cur_a = e[10:8]; cur_d = e[7:0];
    end else begin
      cur_v = 1'b0;
    end
    chk("reg_write", {31'd0, bus.reg_write}, {31'd0, cur_v});
    if (cur_v) begin
      chk("wr_addr", {29'd0, bus.wr_addr}, {29'd0, cur_a});
      chk("wr_data", {24'd0, bus.wr_data}, {24'd0, cur_d});
    end
    chk("pending_cnt", {28'd0, pending_cnt}, $countones(pend_m));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'h11;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd2; bus.ld_data  = 8'h22;
    sb_set = 1'b1; sb_addr = 3'd3; q_valid = 1'b1; q_rs = 3'd3; q_rt = 3'd3;
    @(posedge clk); #1;
    chk("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("rst_wr_addr", {29'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    chk("rst_pending_cnt", {28'd0, pending_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    rst_n = 1'b1;
    idle();

    // Single ALU request
    step(1, 5, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("single_addr", {29'd0, bus.wr_addr}, 32'd5);
    chk("single_data", {24'd0, bus.wr_data}, 32'h3C);
    idle();

    // Three-cycle tie: ALU, load, ALU
    step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0);
    chk("tie0_addr", {29'd0, bus.wr_addr}, 32'd1);
    step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0);
    chk("tie1_addr", {29'd0, bus.wr_addr}, 32'd2);
    step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0);
    chk("tie2_addr", {29'd0, bus.wr_addr}, 32'd1);
    idle();

    // RAW hazard on register 4
    step(0, 0, 0, 0, 0, 0, 1, 4, 1, 4, 0);
    chk("hazard_stall_set", {31'd0, stall}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4);
    step(1, 4, 8'h44, 0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    chk("hazard_stall_clear", {31'd0, stall}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4);

    // Set/clear collision on register 6
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 6, 8'h66, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 1, 6, 6);
    chk("collide_cnt", {28'd0, pending_cnt}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

    // Writeback to register 3 while decode reads it as rt
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 3, 8'h9A, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    idle();

    // Mixed traffic including register 0 and full-scoreboard cases
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, 3'(i), 0, 0, 0);
    chk("full_cnt", {28'd0, pending_cnt}, 32'd8);

    // Reset during an in-flight write, with priority on the load side
    step(1, 7, 8'hA5, 1, 3, 8'h5A, 1, 7, 0, 0, 0);
    bus.alu_valid = 1'b1; bus.ld_valid = 1'b0;
    q_valid = 1'b1; q_rs = 3'd7; q_rt = 3'd7; sb_set = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("midrst_pending_cnt", {28'd0, pending_cnt}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 0);
    chk("postrst_tie_addr", {29'd0, bus.wr_addr}, 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
